button_conditioner: RTL and testbench

Front-end conditioner for the player's push buttons (play, next, …), directly upstream of `music_player`. Each raw, asynchronous, bouncy button input passes through a synchronizer, a debounce state machine and an edge detector. The block emits a one-cycle `pulse` per press, a debounced `held` level, and a one-cycle `long_pulse` after a sustained hold. `pulse[0]` drives `play_button` and `pulse[1]` drives `next_button`.

---
 rtl/button_pkg.sv | 24 ++
 rtl/button_debouncer.sv | 121 ++++++++++++
 rtl/button_conditioner.sv | 31 +++
 tb/tb_button_conditioner.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/button_pkg.sv
// Shared types and helpers for the push-button front end.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    // Bits needed to represent values 0 .. value-1.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// One button channel: two-flop synchronizer, debounce FSM, press/long-press strobes.
//
//   state        | meaning
//   -------------+-----------------------------------------------------
//   IDLE         | button released and stable
//   PRESS_WAIT   | input high, counting stable samples before accepting
//   HELD         | press accepted, long-press timer running
//   RELEASE_WAIT | input low, counting stable samples before releasing
module button_debouncer
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LONG_CYCLES     = 50000000
) (
    input  logic clk,
    input  logic reset,
    input  logic button_in,
    output logic pulse,
    output logic held,
    output logic long_pulse
);

    localparam int CW = clog2(DEBOUNCE_CYCLES + 1);
    localparam int LW = clog2(LONG_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(DEBOUNCE_CYCLES);
    localparam logic [LW-1:0] LCNT_MAX = LW'(LONG_CYCLES);

    logic       sync1_q, sync1_d;
    logic       sync2_q, sync2_d;
    btn_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [LW-1:0] lcnt_q, lcnt_d;
    logic       pulse_q, pulse_d;
    logic       held_q, held_d;
    logic       long_pulse_q, long_pulse_d;
    logic       s;

    assign s = sync2_q;

    always_comb begin
        sync1_d      = button_in;
        sync2_d      = sync1_q;
        state_d      = state_q;
        cnt_d        = cnt_q;
        lcnt_d       = lcnt_q;
        pulse_d      = 1'b0;
        long_pulse_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (s) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = CW'(1);
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = HELD;
                    pulse_d = 1'b1;
                    lcnt_d  = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            HELD: begin
                if (!s) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = CW'(1);
                end else if (lcnt_q != LCNT_MAX) begin
                    // Saturating: the strobe can only fire on the single step into LCNT_MAX.
                    lcnt_d       = lcnt_q + LW'(1);
                    long_pulse_d = (lcnt_q == LCNT_MAX - LW'(1));
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    state_d = HELD;
                end else if (cnt_q == CNT_MAX) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        held_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q      <= 1'b0;
            sync2_q      <= 1'b0;
            state_q      <= IDLE;
            cnt_q        <= '0;
            lcnt_q       <= '0;
            pulse_q      <= 1'b0;
            held_q       <= 1'b0;
            long_pulse_q <= 1'b0;
        end else begin
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lcnt_q       <= lcnt_d;
            pulse_q      <= pulse_d;
            held_q       <= held_d;
            long_pulse_q <= long_pulse_d;
        end
    end

    assign pulse      = pulse_q;
    assign held       = held_q;
    assign long_pulse = long_pulse_q;

endmodule

// File: rtl/button_conditioner.sv
// Array of independent button channels feeding the music player controls.
module button_conditioner
    import button_pkg::*;
#(
    parameter int N_BUTTONS       = 2,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int LONG_CYCLES     = 50000000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_BUTTONS-1:0] button_in,
    output logic [N_BUTTONS-1:0] pulse,
    output logic [N_BUTTONS-1:0] held,
    output logic [N_BUTTONS-1:0] long_pulse
);

    for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .LONG_CYCLES    (LONG_CYCLES)
        ) u_deb (
            .clk       (clk),
            .reset     (reset),
            .button_in (button_in[i]),
            .pulse     (pulse[i]),
            .held      (held[i]),
            .long_pulse(long_pulse[i])
        );
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with DEBOUNCE_CYCLES=4, LONG_CYCLES=20.
module tb_button_conditioner;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] button_in = 2'b00;
    logic [1:0] pulse;
    logic [1:0] held;
    logic [1:0] long_pulse;

    int total = 0;
    int bad   = 0;

    button_conditioner #(
        .N_BUTTONS      (2),
        .DEBOUNCE_CYCLES(4),
        .LONG_CYCLES    (20)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .button_in (button_in),
        .pulse     (pulse),
        .held      (held),
        .long_pulse(long_pulse)
    );

    always #5 clk = ~clk;

    // Drive the raw input, let one active edge sample it, then settle.
    task automatic tick(input logic [1:0] b);
        button_in = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [5:0] exp;
        reset = 1'b0;
        #1;
        total++;
        if ({pulse, held, long_pulse} !== 6'b0) begin
            bad++;
            $display("FAIL reset_t0 got=%b want=%b", {pulse, held, long_pulse}, 6'b0);
        end
        for (int i = 0; i < 3; i++) begin
            tick(2'b11);
            total++;
            if ({pulse, held, long_pulse} !== 6'b0) begin
                bad++;
                $display("FAIL reset_hold cyc=%0d got=%b want=%b", i, {pulse, held, long_pulse}, 6'b0);
            end
        end
        reset = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            tick(2'b11);
            exp = {(i == 6) ? 2'b11 : 2'b00, (i >= 6) ? 2'b11 : 2'b00, 2'b00};
            total++;
            if ({pulse, held, long_pulse} !== exp) begin
                bad++;
                $display("FAIL reset_simul_press cyc=%0d got=%b want=%b", i, {pulse, held, long_pulse}, exp);
            end
        end
        for (int i = 0; i <= 7; i++) begin
            tick(2'b00);
            exp = {2'b00, (i < 6) ? 2'b11 : 2'b00, 2'b00};
            total++;
            if ({pulse, held, long_pulse} !== exp) begin
                bad++;
                $display("FAIL reset_simul_release cyc=%0d got=%b want=%b", i, {pulse, held, long_pulse}, exp);
            end
        end
    endtask

    task automatic test_clean_press();
        logic [5:0] exp;
        for (int i = 0; i <= 20; i++) begin
            tick((i < 10) ? 2'b01 : 2'b00);
            exp = {(i == 6) ? 2'b01 : 2'b00, (i >= 6 && i < 16) ? 2'b01 : 2'b00, 2'b00};
            total++;
            if ({pulse, held, long_pulse} !== exp) begin
                bad++;
                $display("FAIL clean_press cyc=%0d got=%b want=%b", i, {pulse, held, long_pulse}, exp);
            end
        end
    endtask

    task automatic test_bounce();
        logic [5:0] exp;
        logic [6:0] pat;
        logic       b;
        pat = 7'b0111011;  // bit i is the level on cycle i: 1,1,0,1,1,1,0
        for (int i = 0; i <= 25; i++) begin
            b = (i < 7) ? pat[i] : (i <= 16);
            tick({1'b0, b});
            exp = {(i == 13) ? 2'b01 : 2'b00, (i >= 13 && i < 23) ? 2'b01 : 2'b00, 2'b00};
            total++;
            if ({pulse, held, long_pulse} !== exp) begin
                bad++;
                $display("FAIL bounce cyc=%0d got=%b want=%b", i, {pulse, held, long_pulse}, exp);
            end
        end
    endtask

    task automatic test_release_bounce();
        logic [5:0] exp;
        logic       b;
        for (int i = 0; i <= 25; i++) begin
            b = (i < 10) || (i >= 11 && i < 16);
            tick({1'b0, b});
            exp = {(i == 6) ? 2'b01 : 2'b00, (i >= 6 && i < 22) ? 2'b01 : 2'b00, 2'b00};
            total++;
            if ({pulse, held, long_pulse} !== exp) begin
                bad++;
                $display("FAIL release_bounce cyc=%0d got=%b want=%b", i, {pulse, held, long_pulse}, exp);
            end
        end
    endtask

    task automatic test_long_press();
        logic [5:0] exp;
        for (int i = 0; i <= 48; i++) begin
            tick((i < 40) ? 2'b10 : 2'b00);
            exp = {(i == 6) ? 2'b10 : 2'b00, (i >= 6 && i < 46) ? 2'b10 : 2'b00,
                   (i == 26) ? 2'b10 : 2'b00};
            total++;
            if ({pulse, held, long_pulse} !== exp) begin
                bad++;
                $display("FAIL long_press cyc=%0d got=%b want=%b", i, {pulse, held, long_pulse}, exp);
            end
        end
        for (int i = 0; i <= 38; i++) begin
            tick((i < 30) ? 2'b10 : 2'b00);
            exp = {(i == 6) ? 2'b10 : 2'b00, (i >= 6 && i < 36) ? 2'b10 : 2'b00,
                   (i == 26) ? 2'b10 : 2'b00};
            total++;
            if ({pulse, held, long_pulse} !== exp) begin
                bad++;
                $display("FAIL long_repress cyc=%0d got=%b want=%b", i, {pulse, held, long_pulse}, exp);
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [5:0] exp;
        // Five edges with the button high leaves channel 0 in PRESS_WAIT, cnt=3.
        for (int i = 0; i <= 4; i++) begin
            tick(2'b01);
            total++;
            if ({pulse, held, long_pulse} !== 6'b0) begin
                bad++;
                $display("FAIL mid_pre cyc=%0d got=%b want=%b", i, {pulse, held, long_pulse}, 6'b0);
            end
        end
        reset = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            tick(2'b01);
            total++;
            if ({pulse, held, long_pulse} !== 6'b0) begin
                bad++;
                $display("FAIL mid_in_reset cyc=%0d got=%b want=%b", i, {pulse, held, long_pulse}, 6'b0);
            end
        end
        reset = 1'b1;
        for (int i = 0; i <= 8; i++) begin
            tick(2'b01);
            exp = {(i == 6) ? 2'b01 : 2'b00, (i >= 6) ? 2'b01 : 2'b00, 2'b00};
            total++;
            if ({pulse, held, long_pulse} !== exp) begin
                bad++;
                $display("FAIL mid_relatency cyc=%0d got=%b want=%b", i, {pulse, held, long_pulse}, exp);
            end
        end
        // Asynchronous clear while held, observed before any further clock edge.
        reset = 1'b0;
        #1;
        total++;
        if ({pulse, held, long_pulse} !== 6'b0) begin
            bad++;
            $display("FAIL mid_hold_async got=%b want=%b", {pulse, held, long_pulse}, 6'b0);
        end
        tick(2'b00);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(2'b00);
            total++;
            if ({pulse, held, long_pulse} !== 6'b0) begin
                bad++;
                $display("FAIL mid_after cyc=%0d got=%b want=%b", i, {pulse, held, long_pulse}, 6'b0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_bounce();
        test_long_press();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
